// File: rtl/disk_track_loader.sv
// rtl/disk_track_loader.sv - Disk II track image loader: settle, stream source bytes into track RAM.
// Optional trailer checksum enabled by DISK_TRACK_LOADER_CHECKSUM_EN.
module disk_track_loader #(
  parameter int TRACK_BYTES   = 6656,
  parameter int SETTLE_CYCLES = 14318
) (
  input  logic        Clock_14MHz,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        disk1_on,
  input  logic        disk2_on,
  output logic        load_req,
  output logic [5:0]  load_track,
  output logic        load_drive,
  output logic        load_abort,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [13:0] ram_write_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  output logic        busy,
  output logic        load_done,
  output logic        checksum_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, STREAM, DONE} state_t;

  localparam logic [14:0] LAST_IDX = 15'(TRACK_BYTES - 1);
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
  localparam logic [14:0] END_CNT  = 15'(TRACK_BYTES + 1);
`else
  localparam logic [14:0] END_CNT  = 15'(TRACK_BYTES);
`endif
  localparam logic [15:0] SC_LAST  = 16'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [5:0]  st_track_q, st_track_d;
  logic        st_drive_q, st_drive_d;
  logic [14:0] byte_cnt_q, byte_cnt_d;
  logic [5:0]  ld_track_q, ld_track_d;
  logic        ld_drive_q, ld_drive_d;
  logic        rec_valid_q, rec_valid_d;
  logic [5:0]  rec_track_q, rec_track_d;
  logic        rec_drive_q, rec_drive_d;
  logic        wr_we_q, wr_we_d;
  logic [13:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        cks_err_q, cks_err_d;
`endif

  logic active, tgt_drive, stream_chg, rdy, accept, abort_c, done_c;

  assign active     = disk1_on | disk2_on;
  assign tgt_drive  = disk2_on;
  // Dropping the drive counts as a target change while streaming.
  assign stream_chg = (track != ld_track_q) || (tgt_drive != ld_drive_q) || !active;
  assign rdy        = (state_q == STREAM) && !stream_chg && (byte_cnt_q < END_CNT);
  assign accept     = rdy && src_valid;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    st_track_d   = st_track_q;
    st_drive_d   = st_drive_q;
    byte_cnt_d   = byte_cnt_q;
    ld_track_d   = ld_track_q;
    ld_drive_d   = ld_drive_q;
    rec_valid_d  = rec_valid_q;
    rec_track_d  = rec_track_q;
    rec_drive_d  = rec_drive_q;
    wr_we_d      = accept && (byte_cnt_q <= LAST_IDX);
    wr_addr_d    = accept ? byte_cnt_q[13:0] : wr_addr_q;
    wr_data_d    = accept ? src_data : wr_data_q;
    abort_c      = 1'b0;
    done_c       = 1'b0;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
    cks_err_d    = cks_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (active && (!rec_valid_q || track != rec_track_q || tgt_drive != rec_drive_q)) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          st_track_d   = track;
          st_drive_d   = tgt_drive;
        end
      end
      SETTLE: begin
        if (!active) begin
          state_d = IDLE;
        end else if (track != st_track_q || tgt_drive != st_drive_q) begin
          settle_cnt_d = '0;
          st_track_d   = track;
          st_drive_d   = tgt_drive;
        end else if (settle_cnt_q == SC_LAST) begin
          state_d    = STREAM;
          ld_track_d = track;
          ld_drive_d = tgt_drive;
          byte_cnt_d = '0;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
          xor_d      = '0;
          cks_err_d  = 1'b0;
`endif
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      STREAM: begin
        if (stream_chg) begin
          abort_c      = 1'b1;
          rec_valid_d  = 1'b0;
          state_d      = SETTLE;
          settle_cnt_d = '0;
          st_track_d   = track;
          st_drive_d   = tgt_drive;
        end else if (accept) begin
          byte_cnt_d = byte_cnt_q + 15'd1;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
          if (byte_cnt_q <= LAST_IDX) begin
            xor_d = xor_q ^ src_data;
          end else begin
            cks_err_d = (src_data != xor_q);
            state_d   = DONE;
          end
`else
          if (byte_cnt_q == LAST_IDX) state_d = DONE;
`endif
        end
      end
      DONE: begin
        done_c      = 1'b1;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
        rec_valid_d = !cks_err_q;
`else
        rec_valid_d = 1'b1;
`endif
        rec_track_d = ld_track_q;
        rec_drive_d = ld_drive_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_14MHz) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      st_track_q   <= '0;
      st_drive_q   <= 1'b0;
      byte_cnt_q   <= '0;
      ld_track_q   <= '0;
      ld_drive_q   <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_track_q  <= '0;
      rec_drive_q  <= 1'b0;
      wr_we_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
      xor_q        <= '0;
      cks_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      st_track_q   <= st_track_d;
      st_drive_q   <= st_drive_d;
      byte_cnt_q   <= byte_cnt_d;
      ld_track_q   <= ld_track_d;
      ld_drive_q   <= ld_drive_d;
      rec_valid_q  <= rec_valid_d;
      rec_track_q  <= rec_track_d;
      rec_drive_q  <= rec_drive_d;
      wr_we_q      <= wr_we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
      cks_err_q    <= cks_err_d;
`endif
    end
  end

  // Outputs are forced low for the whole reset window, not just after the first edge.
  assign load_req       = !reset && (state_q == STREAM) && !stream_chg;
  assign load_track     = reset ? 6'd0 : ld_track_q;
  assign load_drive     = !reset && ld_drive_q;
  assign load_abort     = !reset && abort_c;
  assign src_ready      = !reset && rdy;
  assign ram_write_addr = reset ? 14'd0 : wr_addr_q;
  assign ram_di         = reset ? 8'd0 : wr_data_q;
  assign ram_we         = !reset && wr_we_q;
  assign busy           = !reset && (state_q != IDLE);
  assign load_done      = !reset && done_c;
`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
  assign checksum_err   = !reset && cks_err_q;
`else
  assign checksum_err   = 1'b0;
`endif

endmodule

// File: tb/tb_disk_track_loader.sv
// tb/tb_disk_track_loader.sv - directed self-checking bench for disk_track_loader (TRACK_BYTES=16, SETTLE_CYCLES=4).
module tb_disk_track_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        disk1_on, disk2_on;
  logic        load_req, load_drive, load_abort;
  logic [5:0]  load_track;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic [13:0] ram_write_addr;
  logic [7:0]  ram_di;
  logic        ram_we, busy, load_done, checksum_err;

  always #5 clk = ~clk;

  disk_track_loader #(.TRACK_BYTES(16), .SETTLE_CYCLES(4)) dut (
    .Clock_14MHz(clk), .reset(reset), .track(track), .disk1_on(disk1_on), .disk2_on(disk2_on),
    .load_req(load_req), .load_track(load_track), .load_drive(load_drive), .load_abort(load_abort),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .ram_write_addr(ram_write_addr), .ram_di(ram_di), .ram_we(ram_we),
    .busy(busy), .load_done(load_done), .checksum_err(checksum_err)
  );

`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
  localparam int BYTES_TAKEN = 17;
`else
  localparam int BYTES_TAKEN = 16;
`endif

  int checks = 0, failures = 0;
  int idx, exp_addr, n_we, n_abort, n_done, gap_we, req_rises, req_k, kcount;
  int req_seen, busy_seen, err_seen;
  logic gap, prev_req, throttle, acc, err_at_req;
  logic [5:0] req_track;
  logic req_drive;
  logic [7:0] base, trailer;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] datum(input int i);
    logic [7:0] off;
    off = 8'(i);
    return (i >= 16) ? trailer : base + off;
  endfunction

  task automatic set_base(input logic [7:0] b);
    logic [7:0] x;
    base = b;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ (b + 8'(i));
    trailer = x;
  endtask

  task automatic clear_stats();
    idx = 0; exp_addr = 0; n_we = 0; n_abort = 0; n_done = 0; gap_we = 0;
    req_rises = 0; req_k = -1; kcount = 0; req_seen = 0; busy_seen = 0; err_seen = 0;
    gap = 1'b0; err_at_req = 1'b0; req_track = '0; req_drive = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (ram_we) begin
      if (gap) gap_we++;
      chk("wr_addr", 32'(ram_write_addr), 32'(exp_addr));
      chk("wr_data", 32'(ram_di), 32'(datum(exp_addr)));
      exp_addr++;
      n_we++;
    end
    if (load_abort) begin n_abort++; gap = 1'b1; end
    if (load_done) n_done++;
    if (load_req) req_seen++;
    if (busy) busy_seen++;
    if (checksum_err) err_seen++;
    if (load_req && !prev_req) begin
      req_rises++;
      if (req_k < 0) req_k = kcount;
      req_track = load_track; req_drive = load_drive; err_at_req = checksum_err;
      idx = 0; exp_addr = 0; gap = 1'b0;
      src_data = datum(0);
    end
    prev_req = load_req;
    acc = src_valid && src_ready;
    @(posedge clk);
    #1;
    if (acc) idx++;
    src_data = datum(idx);
    if (throttle) src_valid = !src_valid;
    kcount++;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && n_done < target; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    reset = 1'b1; track = 6'd5; disk1_on = 1'b1; disk2_on = 1'b0;
    src_valid = 1'b0; src_data = 8'h00; throttle = 1'b0; prev_req = 1'b0;
    set_base(8'h00);
    clear_stats();
    repeat (3) cycle();
    @(negedge clk);
    chk("rst_load_req", load_req, 0);
    chk("rst_load_track", load_track, 0);
    chk("rst_load_drive", load_drive, 0);
    chk("rst_load_abort", load_abort, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_ram_addr", ram_write_addr, 0);
    chk("rst_ram_di", ram_di, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_checksum_err", checksum_err, 0);
    @(posedge clk); #1;

    // Basic load of track 5 on drive 1
    src_valid = 1'b1;
    reset = 1'b0;
    clear_stats();
    wait_done(1);
    chk("b_req_latency", req_k, 5);
    chk("b_req_track", req_track, 5);
    chk("b_req_drive", req_drive, 0);
    chk("b_writes", n_we, 16);
    chk("b_done", n_done, 1);
    chk("b_bytes_taken", idx, BYTES_TAKEN);
    cycle();
    chk("b_idle_busy", busy, 0);

    // Same track stays loaded
    req_seen = 0; busy_seen = 0;
    repeat (100) cycle();
    chk("same_req", req_seen, 0);
    chk("same_busy", busy_seen, 0);

    // Abort after 7 accepted bytes, then reload of track 6
    set_base(8'h20);
    do_reset();
    for (int i = 0; i < 200 && idx < 7; i++) cycle();
    chk("ab_first_req", req_rises, 1);
    track = 6'd6;
    wait_done(1);
    chk("ab_abort_count", n_abort, 1);
    chk("ab_gap_writes", gap_we, 0);
    chk("ab_req_rises", req_rises, 2);
    chk("ab_new_track", req_track, 6);
    chk("ab_writes_after", exp_addr, 16);
    chk("ab_done", n_done, 1);

    // Throttled source on drive 2
    set_base(8'h40);
    disk1_on = 1'b0; disk2_on = 1'b1;
    do_reset();
    throttle = 1'b1;
    wait_done(1);
    throttle = 1'b0; src_valid = 1'b1;
    chk("th_writes", n_we, 16);
    chk("th_last_addr", exp_addr, 16);
    chk("th_drive", req_drive, 1);
    chk("th_done", n_done, 1);

    // Reset in the middle of a stream
    track = 6'd12;
    n_we = 0;
    for (int i = 0; i < 200 && n_we < 3; i++) cycle();
    chk("mr_started", n_we, 3);
    n_abort = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_req", load_req, 0);
    chk("mr_we", ram_we, 0);
    chk("mr_busy", busy, 0);
    @(posedge clk); #1;
    repeat (3) cycle();
    chk("mr_no_abort", n_abort, 0);
    reset = 1'b0;
    clear_stats();
    wait_done(1);
    chk("mr_reload_track", req_track, 12);
    chk("mr_reload_done", n_done, 1);

`ifdef DISK_TRACK_LOADER_CHECKSUM_EN
    set_base(8'h01);
    disk1_on = 1'b1; disk2_on = 1'b0; track = 6'd3;
    do_reset();
    chk("ck_trailer_model", trailer, 8'h10);
    wait_done(1);
    cycle();
    chk("ck_good_err", checksum_err, 0);
    chk("ck_good_done", n_done, 1);
    trailer = 8'h11;
    track = 6'd9;
    wait_done(2);
    cycle();
    chk("ck_bad_err", checksum_err, 1);
    trailer = 8'h10;
    for (int i = 0; i < 100 && req_rises < 3; i++) cycle();
    chk("ck_reload", req_rises, 3);
    chk("ck_reload_track", req_track, 9);
    chk("ck_err_cleared", err_at_req, 0);
    wait_done(3);
    chk("ck_reload_done", n_done, 3);
`else
    chk("nock_err_never", err_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disk_track_loader.md
DISK_TRACK_LOADER -- requirements
Module: disk_track_loader

Interface
REQ-001 SHALL have parameter TRACK_BYTES, default 6656: bytes per track image, legal range 2..16384.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 14318: cycles the track and drive selection must stay stable before a load starts, legal range 1..65535.
REQ-003 SHALL have these ports, one per line as name direction width meaning:
  Clock_14MHz  in  1  sole clock; all logic on its rising edge.
  reset  in  1  synchronous, active-high reset.
  track  in  6  current head track from the Disk II controller.
  disk1_on  in  1  drive 1 motor on.
  disk2_on  in  1  drive 2 motor on.
  load_req  out  1  load request to the storage source.
  load_track  out  6  track being requested.
  load_drive  out  1  drive being requested (0 = drive 1, 1 = drive 2).
  load_abort  out  1  one-cycle pulse cancelling the current request.
  src_data  in  8  track byte from the source.
  src_valid  in  1  src_data is valid.
  src_ready  out  1  loader accepts a byte this cycle.
  ram_write_addr  out  14  track RAM write address.
  ram_di  out  8  track RAM write data.
  ram_we  out  1  track RAM write enable.
  busy  out  1  a load is pending or in progress.
  load_done  out  1  one-cycle pulse when a complete track has been written.
  checksum_err  out  1  sticky checksum mismatch flag (see REQ-019).

Function
REQ-004 The block SHALL implement the states IDLE, SETTLE, STREAM and DONE.
REQ-005 The target drive SHALL be defined as disk2_on; the target is active when disk1_on or disk2_on is high.
REQ-006 IDLE SHALL go to SETTLE when the target is active and any of these differ from the loaded record: valid bit, track, drive.
REQ-007 SETTLE SHALL count cycles in which track and target are unchanged, and SHALL restart the count on any change.
REQ-008 SETTLE SHALL return to IDLE if the target goes inactive.
REQ-009 SETTLE SHALL go to STREAM after SETTLE_CYCLES stable cycles, latching load_track and load_drive and clearing the byte counter.
REQ-010 load_req SHALL be high in STREAM only; load_track and load_drive SHALL stay constant while load_req is high.
REQ-011 src_ready SHALL be high in STREAM only while bytes remain.
REQ-012 A byte SHALL be accepted only on a cycle where src_valid and src_ready are both high.
REQ-013 On each accepted byte, in the next cycle the block SHALL drive ram_we=1, ram_di=the byte and ram_write_addr=the byte index (0-based), then increment the counter. This gives one cycle of latency and at most one write per cycle.
REQ-014 When byte TRACK_BYTES-1 is accepted, the block SHALL go to DONE.
REQ-015 DONE SHALL last one cycle; load_done SHALL be 1 in that cycle.
REQ-016 DONE SHALL set the loaded record (valid, track, drive) and then return to IDLE.
REQ-017 If track or target changes during STREAM, the block SHALL:
  - pulse load_abort for one cycle;
  - deassert load_req and src_ready in that same cycle;
  - clear the loaded valid bit;
  - go to SETTLE.
  A write for a byte accepted in the cycle before the abort SHALL still complete.
REQ-018 busy SHALL be 1 in SETTLE, STREAM and DONE, and 0 in IDLE.

Reset
REQ-020 While reset is high, the block SHALL hold state IDLE.
REQ-021 While reset is high, every output (load_req, load_track, load_drive, load_abort, src_ready, ram_write_addr, ram_di, ram_we, busy, load_done, checksum_err) SHALL be 0.
REQ-022 While reset is high, the byte counter, settle counter and loaded record (including its valid bit) SHALL be cleared.
REQ-023 Reset asserted mid-STREAM SHALL abandon the load without pulsing load_abort.
REQ-024 After reset, the first active drive SHALL always trigger a load.

Configuration
REQ-019 With macro DISK_TRACK_LOADER_CHECKSUM_EN defined:
  - after the last track byte, STREAM SHALL accept one extra byte, which is not written to RAM;
  - if that byte differs from the XOR of all track bytes, checksum_err SHALL be set and the loaded valid bit SHALL stay clear;
  - checksum_err SHALL clear at the start of the next STREAM.
REQ-025 Without DISK_TRACK_LOADER_CHECKSUM_EN:
  - no extra byte SHALL be accepted;
  - checksum_err SHALL be a constant 0;
  - no checksum logic SHALL be synthesised.

Verification (TRACK_BYTES=16, SETTLE_CYCLES=4 unless stated)
REQ-026 Reset release, disk1_on=1, track=5, source supplies bytes 0x00..0x0F with src_valid always high:
  - load_req rises after 4 stable cycles, with load_track=5 and load_drive=0;
  - 16 ram_we pulses, addresses 0..15, data 0x00..0x0F;
  - load_done pulse, then IDLE.
REQ-027 Same track reloaded: after REQ-026, keep track=5 and disk1_on=1 for 100 cycles -> load_req stays 0 and busy stays 0.
REQ-028 Track change mid-stream: track 5 to 6 after 7 accepted bytes:
  - load_abort pulses once and no further ram_we follows;
  - a new load of track 6 restarts at address 0 and completes with load_done.
REQ-029 Throttled source: src_valid toggles every cycle -> exactly 16 writes in order, no duplicates, and the address never skips.
REQ-030 Checksum, with DISK_TRACK_LOADER_CHECKSUM_EN defined, bytes 0x01..0x10:
  - trailer 0x10 gives load_done and checksum_err=0;
  - trailer 0x11 gives checksum_err=1, and a reload is triggered while the drive stays on.
